// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: walks the PC through a synchronous-read imem and
// hands each word to execute over valid/ready, honouring redirects and halt.
module instr_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [4:0]            HALT_OPCODE = 5'd27
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_rd_en,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted,
  output logic [15:0]           issue_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [31:0]           r_ir;
  logic [ADDR_WIDTH-1:0] r_ir_pc;
  logic                  r_ir_valid;
  logic                  r_halted;
  logic [15:0]           r_issue_cnt;

  logic w_hs;
  logic w_is_halt;

  assign w_hs      = (r_state == S_ISSUE) && r_ir_valid && ir_ready;
  assign w_is_halt = (r_ir[31:27] == HALT_OPCODE);

  assign imem_addr  = r_pc;
  assign imem_rd_en = (r_state == S_REQ);
  assign ir         = r_ir;
  assign ir_pc      = r_ir_pc;
  assign ir_valid   = r_ir_valid;
  assign halted     = r_halted;
  assign issue_cnt  = r_issue_cnt;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_ir_pc     <= '0;
      r_ir_valid  <= 1'b0;
      r_halted    <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      if (w_hs) r_issue_cnt <= r_issue_cnt + 16'd1;

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc    <= RESET_PC;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (redirect_en) r_pc    <= redirect_pc;
          else             r_state <= S_RESP;
        end
        S_RESP: begin
          if (redirect_en) begin
            r_pc    <= redirect_pc;
            r_state <= S_REQ;
          end else begin
            r_ir       <= imem_rdata;
            r_ir_pc    <= r_pc;
            r_pc       <= r_pc + ADDR_WIDTH'(1);
            r_ir_valid <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A redirect wins over the halt opcode even when the handshake completes.
          if (redirect_en) begin
            r_pc       <= redirect_pc;
            r_ir_valid <= 1'b0;
            r_state    <= S_REQ;
          end else if (w_hs) begin
            r_ir_valid <= 1'b0;
            if (w_is_halt) begin
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_HALTED: begin
          if (start) begin
            r_halted <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, and a
// randomized run checked against a transaction-level fetch model.
module tb_instr_fetch_unit;

  localparam logic [4:0] HALT = 5'd27;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halted;
  logic [15:0] issue_cnt;

  logic [31:0] mem [256];

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_unit #(
    .ADDR_WIDTH (8),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(5'd27)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .halted     (halted),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  // synchronous-read instruction memory
  always @(posedge clk) if (imem_rd_en === 1'b1) imem_rdata <= mem[imem_addr];

  typedef struct {
    logic        rst, st, rdy, ren;
    logic [7:0]  rpc;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic        e_valid;
    logic [7:0]  e_irpc;
    logic [31:0] e_ir;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, st, rdy, ren, input logic [7:0] rpc,
                     input logic rd, input logic [7:0] addr, input logic v,
                     input logic [7:0] irpc, input logic h, input logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.st = st; r.rdy = rdy; r.ren = ren; r.rpc = rpc;
    r.e_rd = rd; r.e_addr = addr; r.e_valid = v; r.e_irpc = irpc;
    r.e_ir = v ? (32'h1000_0000 + {24'h0, irpc}) : 32'h0;
    r.e_halt = h; r.e_cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input logic r, s, rd, re, input logic [7:0] p);
    sys_rst = r; start = s; ir_ready = rd; redirect_en = re; redirect_pc = p;
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (ir_valid !== 1'b1 && k < 8) begin
      idle_cyc();
      k++;
    end
    chk(nm, {31'h0, ir_valid}, 32'h1);
  endtask

  task automatic fetch_accept(input int n);
    for (int i = 0; i < n; i++) begin
      wait_valid("accept_wait");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    end
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
  endtask

  // Transaction-level model: where the next word comes from, how long it has
  // been in flight, and what has been handed over so far.
  bit          m_run;
  int          m_age;
  logic [7:0]  m_addr;
  bit          m_halted;
  logic [15:0] m_cnt;

  task automatic model_step(input bit rst, st, rdy, ren, input logic [7:0] rpc);
    bit hs;
    if (rst) begin
      m_run = 0; m_age = 0; m_addr = 8'h00; m_halted = 0; m_cnt = 0;
    end else if (!m_run) begin
      if (st) begin m_run = 1; m_age = 0; m_halted = 0; end
    end else begin
      hs = (m_age >= 2) && rdy;
      if (hs) m_cnt++;
      if (ren) begin
        m_addr = rpc; m_age = 0;
      end else if (hs) begin
        if (mem[m_addr][31:27] == HALT) begin m_run = 0; m_halted = 1; end
        m_addr++;
        m_age = 0;
      end else if (m_age < 2) begin
        m_age++;
      end
    end
  endtask

  initial begin
    fill_linear();

    // Straight-line fetch, reset with a handshake pending, then backpressure.
    add(1,0,0,0,0, 0,8'h00,0,8'h00,0,0);
    add(0,1,1,0,0, 1,8'h00,0,8'h00,0,0);
    add(0,0,1,0,0, 0,8'h00,0,8'h00,0,0);
    add(0,0,1,0,0, 0,8'h01,1,8'h00,0,0);
    add(0,0,1,0,0, 1,8'h01,0,8'h00,0,1);
    add(0,0,1,0,0, 0,8'h01,0,8'h00,0,1);
    add(0,0,1,0,0, 0,8'h02,1,8'h01,0,1);
    add(0,0,1,0,0, 1,8'h02,0,8'h00,0,2);
    add(0,0,1,0,0, 0,8'h02,0,8'h00,0,2);
    add(0,0,1,0,0, 0,8'h03,1,8'h02,0,2);
    add(0,0,1,0,0, 1,8'h03,0,8'h00,0,3);
    add(0,0,1,0,0, 0,8'h03,0,8'h00,0,3);
    add(0,0,1,0,0, 0,8'h04,1,8'h03,0,3);
    add(0,0,1,0,0, 1,8'h04,0,8'h00,0,4);
    add(0,0,1,0,0, 0,8'h04,0,8'h00,0,4);
    add(0,0,1,0,0, 0,8'h05,1,8'h04,0,4);
    add(1,0,1,0,0, 0,8'h00,0,8'h00,0,0);
    add(0,1,0,0,0, 1,8'h00,0,8'h00,0,0);
    add(0,0,0,0,0, 0,8'h00,0,8'h00,0,0);
    for (int i = 0; i < 6; i++) add(0,0,0,0,0, 0,8'h01,1,8'h00,0,0);
    add(0,0,1,0,0, 1,8'h01,0,8'h00,0,1);
    add(0,0,1,0,0, 0,8'h01,0,8'h00,0,1);
    add(0,0,1,0,0, 0,8'h02,1,8'h01,0,1);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].st, tbl[i].rdy, tbl[i].ren, tbl[i].rpc);
      chk($sformatf("vec%0d_rd_en", i), {31'h0, imem_rd_en}, {31'h0, tbl[i].e_rd});
      chk($sformatf("vec%0d_addr", i), {24'h0, imem_addr}, {24'h0, tbl[i].e_addr});
      chk($sformatf("vec%0d_valid", i), {31'h0, ir_valid}, {31'h0, tbl[i].e_valid});
      chk($sformatf("vec%0d_halted", i), {31'h0, halted}, {31'h0, tbl[i].e_halt});
      chk($sformatf("vec%0d_cnt", i), {16'h0, issue_cnt}, {16'h0, tbl[i].e_cnt});
      if (tbl[i].e_valid || tbl[i].rst) begin
        chk($sformatf("vec%0d_ir_pc", i), {24'h0, ir_pc}, {24'h0, tbl[i].e_irpc});
        chk($sformatf("vec%0d_ir", i), ir, tbl[i].e_ir);
      end
    end

    // Redirect and start in IDLE: redirect ignored, start wins.
    cyc(1,0,0,0,0);
    cyc(0,0,0,1,8'h33);
    chk("idle_redir_rd", {31'h0, imem_rd_en}, 32'h0);
    chk("idle_redir_addr", {24'h0, imem_addr}, 32'h0);
    cyc(0,1,0,1,8'h33);
    chk("idle_start_rd", {31'h0, imem_rd_en}, 32'h1);
    chk("idle_start_addr", {24'h0, imem_addr}, 32'h0);

    // Redirect during RESP of address 2.
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    fetch_accept(2);
    chk("redir_req2_addr", {24'h0, imem_addr}, 32'h02);
    idle_cyc();
    cyc(0,0,0,1,8'h40);
    chk("redir_rd", {31'h0, imem_rd_en}, 32'h1);
    chk("redir_addr", {24'h0, imem_addr}, 32'h40);
    chk("redir_valid", {31'h0, ir_valid}, 32'h0);
    wait_valid("redir_wait");
    chk("redir_ir_pc", {24'h0, ir_pc}, 32'h40);
    chk("redir_ir", ir, 32'h1000_0040);
    chk("redir_cnt", {16'h0, issue_cnt}, 32'd2);

    // Handshake and redirect in the same cycle at address 5.
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    fetch_accept(5);
    wait_valid("hsr_wait");
    chk("hsr_ir_pc5", {24'h0, ir_pc}, 32'h05);
    cyc(0,0,1,1,8'h10);
    chk("hsr_cnt", {16'h0, issue_cnt}, 32'd6);
    chk("hsr_rd", {31'h0, imem_rd_en}, 32'h1);
    chk("hsr_addr", {24'h0, imem_addr}, 32'h10);
    wait_valid("hsr_wait2");
    chk("hsr_ir_pc", {24'h0, ir_pc}, 32'h10);

    // Halt at word 3, stays stopped, then resumes at 4.
    mem[3] = {HALT, 27'h3};
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    fetch_accept(3);
    wait_valid("halt_wait");
    cyc(0,0,1,0,0);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_valid", {31'h0, ir_valid}, 32'h0);
    chk("halt_cnt", {16'h0, issue_cnt}, 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,1,1,8'h50);
      chk("halt_no_rd", {31'h0, imem_rd_en}, 32'h0);
      chk("halt_hold", {31'h0, halted}, 32'h1);
    end
    cyc(0,1,0,0,0);
    chk("resume_halted", {31'h0, halted}, 32'h0);
    chk("resume_rd", {31'h0, imem_rd_en}, 32'h1);
    chk("resume_addr", {24'h0, imem_addr}, 32'h04);

    // Redirect on the halt handshake cancels the halt.
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    fetch_accept(3);
    wait_valid("haltr_wait");
    cyc(0,0,1,1,8'h20);
    chk("haltr_halted", {31'h0, halted}, 32'h0);
    chk("haltr_rd", {31'h0, imem_rd_en}, 32'h1);
    chk("haltr_addr", {24'h0, imem_addr}, 32'h20);
    chk("haltr_cnt", {16'h0, issue_cnt}, 32'd4);
    fill_linear();

    // PC wraps from 8'hFF to 8'h00.
    cyc(1,0,0,0,0);
    cyc(0,1,0,0,0);
    wait_valid("wrap_wait0");
    cyc(0,0,1,1,8'hFF);
    chk("wrap_req_ff", {24'h0, imem_addr}, 32'hFF);
    wait_valid("wrap_wait");
    chk("wrap_ir_pc", {24'h0, ir_pc}, 32'hFF);
    cyc(0,0,1,0,0);
    chk("wrap_rd", {31'h0, imem_rd_en}, 32'h1);
    chk("wrap_addr", {24'h0, imem_addr}, 32'h00);

    // Randomized run against the model.
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 7) == 0) mem[i][31:27] = HALT;
    end
    for (int c = 0; c < 1500; c++) begin
      bit r, s, rd, re;
      logic [7:0] p;
      r  = (c == 0) || ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 11) == 0);
      p  = 8'($urandom_range(0, 255));
      model_step(r, s, rd, re, p);
      cyc(r, s, rd, re, p);
      chk("rnd_rd_en", {31'h0, imem_rd_en}, {31'h0, m_run && m_age == 0});
      chk("rnd_valid", {31'h0, ir_valid}, {31'h0, m_run && m_age >= 2});
      chk("rnd_halted", {31'h0, halted}, {31'h0, m_halted});
      chk("rnd_cnt", {16'h0, issue_cnt}, {16'h0, m_cnt});
      if (!m_run || m_age == 0) chk("rnd_addr", {24'h0, imem_addr}, {24'h0, m_addr});
      if (m_run && m_age >= 2) begin
        chk("rnd_ir_pc", {24'h0, ir_pc}, {24'h0, m_addr});
        chk("rnd_ir", ir, mem[m_addr]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
